// File: rtl/face_detect_mul_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : face_detect_mul_pkg
// Description : Shared widths, default multiplier latency and id-width helper
//               for the face-detect shared multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package face_detect_mul_pkg;

  // Default pipeline depth of the shared multiplier
  localparam int MUL_LAT_DEFAULT = 3;

  // Operand and result widths
  localparam int A_WIDTH = 8;   // unsigned operand
  localparam int B_WIDTH = 24;  // signed operand
  localparam int P_WIDTH = 24;  // truncated signed product

  typedef logic [A_WIDTH-1:0] a_t;
  typedef logic [B_WIDTH-1:0] b_t;
  typedef logic [P_WIDTH-1:0] p_t;

  // Width of a requester index; never narrower than one bit
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/face_detect_mul_mul_8ns_24s_24_4_1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : face_detect_mul_mul_8ns_24s_24_4_1
// Description : Pipelined unsigned-8 x signed-24 multiplier, low 24 bits of
//               the product, LAT clock-enabled stages deep.
// Revision    : 1.0 - initial release
// ============================================================================
module face_detect_mul_mul_8ns_24s_24_4_1
  import face_detect_mul_pkg::*;
#(
  parameter int LAT = MUL_LAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  a_t   din0,
  input  b_t   din1,
  output p_t   dout
);

  // Only the low 24 bits are kept, so a 24-bit multiply is exact for them;
  // the unsigned operand is zero-extended so it is never read as negative.
  logic signed [P_WIDTH-1:0] a_ext;
  logic signed [P_WIDTH-1:0] prod;
  p_t                        stage [LAT];

  assign a_ext = {{(P_WIDTH-A_WIDTH){1'b0}}, din0};
  assign prod  = a_ext * $signed(din1);

  // Product shift chain; the first stage captures straight from the operands
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < LAT; s++) stage[s] <= '0;
    end else if (ce) begin
      stage[0] <= prod;
      for (int s = 1; s < LAT; s++) stage[s] <= stage[s-1];
    end
  end

  assign dout = stage[LAT-1];

endmodule
`default_nettype wire

// File: rtl/face_detect_mul_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : face_detect_mul_arb
// Description : Round-robin arbiter sharing one pipelined multiplier between
//               N_REQ requesters, with a valid/id tag pipe and output stall.
// Revision    : 1.0 - initial release
// ============================================================================
module face_detect_mul_arb
  import face_detect_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*A_WIDTH-1:0]     req_a,
  input  logic [N_REQ*B_WIDTH-1:0]     req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [id_width(N_REQ)-1:0]   res_id,
  output logic [P_WIDTH-1:0]           res_data,
  output logic                         busy
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               pipe_ce;
  logic               transfer;
  logic [MUL_LAT-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [MUL_LAT];
  a_t                 a_arr  [N_REQ];
  b_t                 b_arr  [N_REQ];

  // Split the flat operand buses into per-requester slices
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*A_WIDTH +: A_WIDTH];
    assign b_arr[g] = req_b[g*B_WIDTH +: B_WIDTH];
  end

  // Only a held result stalls the pipe; a bubble at the output never does
  assign pipe_ce = !(res_valid && !res_ready);

  // Round-robin search starting one past the previous winner
  always_comb begin
    int idx;
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req_valid[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  // Accept only the winner, only while the pipe advances and out of reset
  assign transfer = win_found && pipe_ce && ap_rst_n;

  // One-hot ready for the winning requester
  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[win_id] = 1'b1;
  end

  // Tag pipe and grant pointer; reset discards everything in flight
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tag_valid  <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_id[s] <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      if (pipe_ce) begin
        tag_valid[0] <= transfer;
        tag_id[0]    <= transfer ? win_id : '0;
        for (int s = 1; s < MUL_LAT; s++) begin
          tag_valid[s] <= tag_valid[s-1];
          tag_id[s]    <= tag_id[s-1];
        end
      end
      if (transfer) last_grant <= win_id;
    end
  end

  face_detect_mul_mul_8ns_24s_24_4_1 #(
    .LAT (MUL_LAT)
  ) u_mul (
    .clk   (ap_clk),
    .reset (!ap_rst_n),
    .ce    (pipe_ce),
    .din0  (a_arr[win_id]),
    .din1  (b_arr[win_id]),
    .dout  (res_data)
  );

  assign res_valid = tag_valid[MUL_LAT-1];
  assign res_id    = tag_id[MUL_LAT-1];
  assign busy      = |tag_valid;

endmodule
`default_nettype wire

// File: tb/tb_face_detect_mul_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_face_detect_mul_arb
// Description : Directed self-checking bench for face_detect_mul_arb
//               (N_REQ=4, MUL_LAT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_face_detect_mul_arb;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [95:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [23:0] res_data;
  logic        busy;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_got;
  logic [31:0] mon_exp;

  face_detect_mul_arb #(
    .N_REQ   (4),
    .MUL_LAT (3)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [23:0] b);
    req_a[8*i +: 8]   = a;
    req_b[24*i +: 24] = b;
  endtask

  // Every consumed result must match the oldest outstanding expectation
  always @(negedge ap_clk) begin
    if (ap_rst_n && res_valid && res_ready) begin
      mon_got = {6'd0, res_id, res_data};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_result: observed=%0h expected=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        assert (mon_got === mon_exp) else begin
          bad++;
          $error("FAIL result_order: observed=%0h expected=%0h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: observed=timeout expected=finish");
  end

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = 4'hF;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    #3;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_res_id",    {30'd0, res_id},    32'd0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    req_valid = 4'h0;

    // Single op: 3 * -5 = -15, visible three cycles after the transfer
    tick();
    set_op(0, 8'd3, 24'hFFFFFB);
    req_valid = 4'b0001;
    #1;
    chk("s1_ready", {28'd0, req_ready}, 32'h1);
    exp_q.push_back({8'd0, 24'hFFFFF1});
    tick();
    req_valid = 4'b0000;
    #1;
    chk("s1_c1_valid", {31'd0, res_valid}, 32'd0);
    chk("s1_c1_busy",  {31'd0, busy},      32'd1);
    tick();
    chk("s1_c2_valid", {31'd0, res_valid}, 32'd0);
    tick();
    chk("s1_c3_valid", {31'd0, res_valid}, 32'd1);
    chk("s1_c3_id",    {30'd0, res_id},    32'd0);
    chk("s1_c3_data",  {8'd0, res_data},   32'h00FFFFF1);
    tick();
    chk("s1_c4_valid", {31'd0, res_valid}, 32'd0);
    chk("s1_c4_busy",  {31'd0, busy},      32'd0);

    // Truncation: 255 * 0x7FFFFF = 0x7F7FFF01 -> 0x7FFF01
    tick();
    set_op(1, 8'd255, 24'h7FFFFF);
    req_valid = 4'b0010;
    #1;
    chk("s2_ready", {28'd0, req_ready}, 32'h2);
    exp_q.push_back({8'd1, 24'h7FFF01});
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("s2_valid", {31'd0, res_valid}, 32'd1);
    chk("s2_data",  {8'd0, res_data},   32'h007FFF01);
    tick();

    // Pointer fairness: req2 alone, then req0+req2 -> req0 then req2
    tick();
    set_op(2, 8'd2, 24'd10);
    set_op(0, 8'd4, 24'hFFFFFF);
    req_valid = 4'b0100;
    #1;
    chk("s3_g0", {28'd0, req_ready}, 32'h4);
    exp_q.push_back({8'd2, 24'd20});
    tick();
    req_valid = 4'b0101;
    #1;
    chk("s3_g1", {28'd0, req_ready}, 32'h1);
    exp_q.push_back({8'd0, 24'hFFFFFC});
    tick();
    chk("s3_g2", {28'd0, req_ready}, 32'h4);
    exp_q.push_back({8'd2, 24'd20});
    tick();
    req_valid = 4'b0000;
    repeat (4) tick();
    chk("s3_busy", {31'd0, busy}, 32'd0);

    // Reset with two ops in flight (first one held on the output)
    set_op(1, 8'd5, 24'd5);
    set_op(3, 8'd6, 24'd7);
    req_valid = 4'b1010;
    #1;
    chk("s5_g0", {28'd0, req_ready}, 32'h8);
    tick();
    chk("s5_g1", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0000;
    res_ready = 1'b0;
    tick();
    chk("s5_held_valid", {31'd0, res_valid}, 32'd1);
    chk("s5_held_id",    {30'd0, res_id},    32'd3);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("s5_rst_busy",  {31'd0, busy},      32'd0);
    chk("s5_rst_id",    {30'd0, res_id},    32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s5_no_stale", {31'd0, res_valid}, 32'd0);
    end

    // Back-to-back: all valid, grants 0,1,2,3,0
    set_op(0, 8'd1, 24'hFFFFFE);
    set_op(1, 8'd2, 24'd7);
    set_op(2, 8'd3, 24'd1000);
    set_op(3, 8'd4, 24'hFFFFFD);
    for (int k = 0; k < 5; k++) begin
      tick();
      req_valid = 4'hF;
      #1;
      case (k % 4)
        0: begin chk("s4_grant0", {28'd0, req_ready}, 32'h1); exp_q.push_back({8'd0, 24'hFFFFFE}); end
        1: begin chk("s4_grant1", {28'd0, req_ready}, 32'h2); exp_q.push_back({8'd1, 24'h00000E}); end
        2: begin chk("s4_grant2", {28'd0, req_ready}, 32'h4); exp_q.push_back({8'd2, 24'h000BB8}); end
        default: begin chk("s4_grant3", {28'd0, req_ready}, 32'h8); exp_q.push_back({8'd3, 24'hFFFFF4}); end
      endcase
    end

    // Stall with full pipe: outputs frozen on transfer 2 (id2, 3000)
    tick();
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("s6_ready", {28'd0, req_ready}, 32'h0);
      chk("s6_valid", {31'd0, res_valid}, 32'd1);
      chk("s6_id",    {30'd0, res_id},    32'd2);
      chk("s6_data",  {8'd0, res_data},   32'h00000BB8);
      chk("s6_busy",  {31'd0, busy},      32'd1);
      tick();
    end
    // Release: a new transfer is accepted in the same cycle a result leaves
    res_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    chk("s6_accept_on_consume", {28'd0, req_ready}, 32'h2);
    exp_q.push_back({8'd1, 24'h00000E});
    tick();
    req_valid = 4'b0000;
    repeat (6) tick();
    chk("end_busy",    {31'd0, busy}, 32'd0);
    chk("end_pending", exp_q.size(),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
